// File: rtl/read_data_router_pkg.sv
// -----------------------------------------------------------------------------
// read_data_router_pkg
//   Shared definitions for the AXI read-data (R) return path of the bridge.
//   Contents:
//     - default `AXI_* width defines (kept if the bridge already set them)
//     - ID_W / IDS_W / DATA_W widths derived from those defines
//     - TAG_BIT: the RID bit that carries the master tag (0 = M0, 1 = M1)
//     - r_state_e: IDLE / LOCK state of the router
//     - RRESP encodings
//     - tag_of(): extracts the master tag from a slave-side RID
//   Ports: none (package).
// -----------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package read_data_router_pkg;

   localparam int ID_W    = `AXI_ID_BITS;
   localparam int IDS_W   = `AXI_IDS_BITS;
   localparam int DATA_W  = `AXI_DATA_BITS;
   localparam int TAG_BIT = `AXI_ID_BITS;

   localparam logic [1:0] RRESP_OKAY   = 2'b00;
   localparam logic [1:0] RRESP_EXOKAY = 2'b01;
   localparam logic [1:0] RRESP_SLVERR = 2'b10;
   localparam logic [1:0] RRESP_DECERR = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } r_state_e;

   // Master tag carried in the slave-side RID.
   function automatic logic tag_of(input logic [IDS_W-1:0] rid);
      return rid[TAG_BIT];
   endfunction

endpackage

// File: rtl/read_data_router_if.sv
// -----------------------------------------------------------------------------
// read_data_router_if
//   Bundles the R-channel signals of the three slave ports (S0..S2) and the two
//   master ports (M0, M1) seen by the read-data router.
//   Modports:
//     slave  : the router's view - takes slave beats and master RREADY in,
//              drives RREADY_S* and the routed master-side beat out.
//     master : the surrounding fabric's view - the mirror image of slave.
//   Handshake: a beat transfers on a rising clk edge where RVALID and RREADY
//   of the same port are both 1; a slave holds RID/RDATA/RRESP/RLAST stable
//   while RVALID=1 and RREADY=0, and RVALID never depends on RREADY.
// -----------------------------------------------------------------------------
interface read_data_router_if;
   import read_data_router_pkg::*;

   // Slave side (beats coming back from S0..S2)
   logic [IDS_W-1:0]  RID_S0,    RID_S1,    RID_S2;
   logic [DATA_W-1:0] RDATA_S0,  RDATA_S1,  RDATA_S2;
   logic [1:0]        RRESP_S0,  RRESP_S1,  RRESP_S2;
   logic              RLAST_S0,  RLAST_S1,  RLAST_S2;
   logic              RVALID_S0, RVALID_S1, RVALID_S2;
   logic              RREADY_S0, RREADY_S1, RREADY_S2;

   // Master side (beats delivered to M0 / M1)
   logic [ID_W-1:0]   RID_M0,    RID_M1;
   logic [DATA_W-1:0] RDATA_M0,  RDATA_M1;
   logic [1:0]        RRESP_M0,  RRESP_M1;
   logic              RLAST_M0,  RLAST_M1;
   logic              RVALID_M0, RVALID_M1;
   logic              RREADY_M0, RREADY_M1;

   modport slave (
      input  RID_S0, RID_S1, RID_S2,
      input  RDATA_S0, RDATA_S1, RDATA_S2,
      input  RRESP_S0, RRESP_S1, RRESP_S2,
      input  RLAST_S0, RLAST_S1, RLAST_S2,
      input  RVALID_S0, RVALID_S1, RVALID_S2,
      output RREADY_S0, RREADY_S1, RREADY_S2,
      output RID_M0, RID_M1,
      output RDATA_M0, RDATA_M1,
      output RRESP_M0, RRESP_M1,
      output RLAST_M0, RLAST_M1,
      output RVALID_M0, RVALID_M1,
      input  RREADY_M0, RREADY_M1
   );

   modport master (
      output RID_S0, RID_S1, RID_S2,
      output RDATA_S0, RDATA_S1, RDATA_S2,
      output RRESP_S0, RRESP_S1, RRESP_S2,
      output RLAST_S0, RLAST_S1, RLAST_S2,
      output RVALID_S0, RVALID_S1, RVALID_S2,
      input  RREADY_S0, RREADY_S1, RREADY_S2,
      input  RID_M0, RID_M1,
      input  RDATA_M0, RDATA_M1,
      input  RRESP_M0, RRESP_M1,
      input  RLAST_M0, RLAST_M1,
      input  RVALID_M0, RVALID_M1,
      output RREADY_M0, RREADY_M1
   );

endinterface

// File: rtl/read_data_router_rr_arbiter3.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
//   Purely combinational 3-way round-robin picker, shared with the B-channel
//   return path.
//   Ports:
//     request [2:0] in  : per-requester request lines
//     ptr     [1:0] in  : highest-priority requester this cycle (0..2)
//     grant   [1:0] out : index of the first requester at or after ptr,
//                         wrapping 2 -> 0 (0 when nothing requests)
//     any_req       out : at least one request line is high
// -----------------------------------------------------------------------------
module rr_arbiter3 (
   input  logic [2:0] request,
   input  logic [1:0] ptr,
   output logic [1:0] grant,
   output logic       any_req
);

   // (ptr + offset) mod 3 for a sum that never exceeds 5.
   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   logic [1:0] idx;

   // Scan offsets from farthest to nearest so the nearest requester at or
   // after ptr is the last, and therefore winning, assignment.
   always_comb begin
      grant   = '0;
      idx     = '0;
      any_req = |request;
      for (int i = 2; i >= 0; i--) begin
         idx = wrap3({1'b0, ptr} + 3'(i));
         if (request[idx]) begin
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/read_data_router.sv
// -----------------------------------------------------------------------------
// read_data_router
//   R-channel return path: collects read beats from slaves S0..S2 and routes
//   each beat to master M0 or M1 according to the master tag in RID. One beat
//   is in flight at a time; a burst keeps its slave locked to the path until
//   its RLAST beat transfers, and a round-robin arbiter chooses among
//   competing slaves when the path is free.
//
//   Optional feature macro: READ_WATCHDOG_EN
//     defined   : stall counter + sticky rd_timeout output
//     undefined : no counter, no rd_timeout port
//
//   Parameters:
//     NUM_S          : slave count (fixed at 3; sizes the arbiter pointer)
//     TIMEOUT_CYCLES : stalled LOCK cycles before rd_timeout sets
//   Ports:
//     clk        in  : clock
//     rst        in  : asynchronous active-high reset
//     bus        if  : read_data_router_if.slave (all R-channel signals)
//     rd_timeout out : sticky watchdog flag (READ_WATCHDOG_EN only)
//     dbg_state  out : current router state (IDLE / LOCK)
//     dbg_owner  out : slave holding the path while in LOCK
//     dbg_ptr    out : round-robin pointer (highest-priority slave in IDLE)
// -----------------------------------------------------------------------------
module read_data_router
   import read_data_router_pkg::*;
#(
   parameter int  NUM_S          = 3,
   parameter int  TIMEOUT_CYCLES = 255,
   localparam int PTR_W          = $clog2(NUM_S)
) (
   input  logic                clk,
   input  logic                rst,
   read_data_router_if.slave   bus,
`ifdef READ_WATCHDOG_EN
   output logic                rd_timeout,
`endif
   output r_state_e            dbg_state,
   output logic [PTR_W-1:0]    dbg_owner,
   output logic [PTR_W-1:0]    dbg_ptr
);

   // ---------------------------------------------------------------------
   // Slave-side signals gathered into indexable arrays
   // ---------------------------------------------------------------------
   logic [IDS_W-1:0]  rid_s   [NUM_S];
   logic [DATA_W-1:0] rdata_s [NUM_S];
   logic [1:0]        rresp_s [NUM_S];
   logic [NUM_S-1:0]  rlast_s;
   logic [NUM_S-1:0]  rvalid_s;
   logic [NUM_S-1:0]  rready_s;

   assign rid_s[0]   = bus.RID_S0;
   assign rid_s[1]   = bus.RID_S1;
   assign rid_s[2]   = bus.RID_S2;
   assign rdata_s[0] = bus.RDATA_S0;
   assign rdata_s[1] = bus.RDATA_S1;
   assign rdata_s[2] = bus.RDATA_S2;
   assign rresp_s[0] = bus.RRESP_S0;
   assign rresp_s[1] = bus.RRESP_S1;
   assign rresp_s[2] = bus.RRESP_S2;
   assign rlast_s    = {bus.RLAST_S2,  bus.RLAST_S1,  bus.RLAST_S0};
   assign rvalid_s   = {bus.RVALID_S2, bus.RVALID_S1, bus.RVALID_S0};

   assign bus.RREADY_S0 = rready_s[0];
   assign bus.RREADY_S1 = rready_s[1];
   assign bus.RREADY_S2 = rready_s[2];

   // RID bits above the master tag carry nothing for this path.
   logic unused_rid_hi;
   assign unused_rid_hi = ^{rid_s[0][IDS_W-1:TAG_BIT+1],
                            rid_s[1][IDS_W-1:TAG_BIT+1],
                            rid_s[2][IDS_W-1:TAG_BIT+1]};

   // ---------------------------------------------------------------------
   // Master-side signals
   // ---------------------------------------------------------------------
   logic [ID_W-1:0]   rid_m   [2];
   logic [DATA_W-1:0] rdata_m [2];
   logic [1:0]        rresp_m [2];
   logic [1:0]        rlast_m;
   logic [1:0]        rvalid_m;
   logic [1:0]        rready_m;

   assign rready_m = {bus.RREADY_M1, bus.RREADY_M0};

   assign bus.RID_M0    = rid_m[0];
   assign bus.RID_M1    = rid_m[1];
   assign bus.RDATA_M0  = rdata_m[0];
   assign bus.RDATA_M1  = rdata_m[1];
   assign bus.RRESP_M0  = rresp_m[0];
   assign bus.RRESP_M1  = rresp_m[1];
   assign bus.RLAST_M0  = rlast_m[0];
   assign bus.RLAST_M1  = rlast_m[1];
   assign bus.RVALID_M0 = rvalid_m[0];
   assign bus.RVALID_M1 = rvalid_m[1];

   // ---------------------------------------------------------------------
   // State and arbitration
   // ---------------------------------------------------------------------
   r_state_e         state;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] rr_ptr;
   logic [1:0]       win;
   logic             any_req;

   rr_arbiter3 u_arb (
      .request (rvalid_s),
      .ptr     (rr_ptr),
      .grant   (win),
      .any_req (any_req)
   );

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_S - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   logic [PTR_W-1:0] sel;
   logic             route_en;
   logic             dest;
   logic             hs;
   logic             sel_last;

   // In LOCK the owner keeps the path even while its RVALID is low; in IDLE
   // the path opens only when some slave is presenting a beat. Reset gates
   // the whole path so the outputs fall to zero as soon as rst rises.
   assign sel      = (state == LOCK) ? owner : win;
   assign route_en = !rst && ((state == LOCK) || any_req);
   assign dest     = tag_of(rid_s[sel]);
   assign sel_last = rlast_s[sel];
   assign hs       = route_en && rvalid_s[sel] && rready_m[dest];

   always_comb begin
      rready_s = '0;
      rlast_m  = '0;
      rvalid_m = '0;
      for (int m = 0; m < 2; m++) begin
         rid_m[m]   = '0;
         rdata_m[m] = '0;
         rresp_m[m] = '0;
      end
      if (route_en) begin
         rvalid_m[dest] = rvalid_s[sel];
         rid_m[dest]    = rid_s[sel][ID_W-1:0];
         rdata_m[dest]  = rdata_s[sel];
         rresp_m[dest]  = rresp_s[sel];
         rlast_m[dest]  = rlast_s[sel];
         rready_s[sel]  = rready_m[dest];
      end
   end

   // A winner that does not finish in the same cycle is locked in, so a beat
   // already shown to a master is never swapped for another slave's beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  if (hs && sel_last) begin
                     rr_ptr <= ptr_next(win);
                  end else begin
                     state <= LOCK;
                     owner <= win;
                  end
               end
            end
            LOCK: begin
               if (hs && sel_last) begin
                  state  <= IDLE;
                  rr_ptr <= ptr_next(owner);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;
   assign dbg_owner = owner;
   assign dbg_ptr   = rr_ptr;

`ifdef READ_WATCHDOG_EN
   // ---------------------------------------------------------------------
   // Stall watchdog: counts LOCK cycles without a transfer, saturates at
   // TIMEOUT_CYCLES and raises a flag that only reset clears.
   // ---------------------------------------------------------------------
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            stall;

   assign stall = (state == LOCK) && !hs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt     <= '0;
         rd_timeout <= 1'b0;
      end else begin
         if (!stall) begin
            wd_cnt <= '0;
         end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
            // Flag rises in the same cycle the count reaches the limit.
            if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
               rd_timeout <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_read_data_router.sv
// -----------------------------------------------------------------------------
// tb_read_data_router
//   Directed bench for read_data_router. Slave beats are queued per slave and
//   presented by a slave-model process; every beat expected at a master is
//   pushed into exp_q in delivery order and a monitor compares each master
//   handshake against the queue head. Built with READ_WATCHDOG_EN it also
//   exercises the stall watchdog (TIMEOUT_CYCLES = 8).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_read_data_router;
   import read_data_router_pkg::*;

   localparam int SLV_W = IDS_W + DATA_W + 3;
   localparam int SB_W  = 1 + ID_W + DATA_W + 3;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------------------------------------------------------------
   // DUT
   // ---------------------------------------------------------------------
   read_data_router_if bus ();
   r_state_e   dbg_state;
   logic [1:0] dbg_owner;
   logic [1:0] dbg_ptr;
`ifdef READ_WATCHDOG_EN
   logic       rd_timeout;
`endif

   read_data_router #(
      .NUM_S          (3),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
`ifdef READ_WATCHDOG_EN
      .rd_timeout (rd_timeout),
`endif
      .dbg_state  (dbg_state),
      .dbg_owner  (dbg_owner),
      .dbg_ptr    (dbg_ptr)
   );

   // Slave-side drive
   logic [IDS_W-1:0]  s_rid   [3];
   logic [DATA_W-1:0] s_data  [3];
   logic [1:0]        s_resp  [3];
   logic [2:0]        s_last;
   logic [2:0]        s_valid;
   logic [2:0]        s_ready;

   assign bus.RID_S0    = s_rid[0];
   assign bus.RID_S1    = s_rid[1];
   assign bus.RID_S2    = s_rid[2];
   assign bus.RDATA_S0  = s_data[0];
   assign bus.RDATA_S1  = s_data[1];
   assign bus.RDATA_S2  = s_data[2];
   assign bus.RRESP_S0  = s_resp[0];
   assign bus.RRESP_S1  = s_resp[1];
   assign bus.RRESP_S2  = s_resp[2];
   assign bus.RLAST_S0  = s_last[0];
   assign bus.RLAST_S1  = s_last[1];
   assign bus.RLAST_S2  = s_last[2];
   assign bus.RVALID_S0 = s_valid[0];
   assign bus.RVALID_S1 = s_valid[1];
   assign bus.RVALID_S2 = s_valid[2];
   assign s_ready       = {bus.RREADY_S2, bus.RREADY_S1, bus.RREADY_S0};

   // Master side
   logic [1:0]        m_ready = 2'b00;
   logic [1:0]        m_valid;
   logic [1:0]        m_last;
   logic [ID_W-1:0]   m_id   [2];
   logic [DATA_W-1:0] m_data [2];
   logic [1:0]        m_resp [2];

   assign bus.RREADY_M0 = m_ready[0];
   assign bus.RREADY_M1 = m_ready[1];
   assign m_valid   = {bus.RVALID_M1, bus.RVALID_M0};
   assign m_last    = {bus.RLAST_M1, bus.RLAST_M0};
   assign m_id[0]   = bus.RID_M0;
   assign m_id[1]   = bus.RID_M1;
   assign m_data[0] = bus.RDATA_M0;
   assign m_data[1] = bus.RDATA_M1;
   assign m_resp[0] = bus.RRESP_M0;
   assign m_resp[1] = bus.RRESP_M1;

   // ---------------------------------------------------------------------
   // Check helper and queues
   // ---------------------------------------------------------------------
   logic [SLV_W-1:0] slv_q [3][$];
   logic [SB_W-1:0]  exp_q [$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------
   // Queue a beat on slave s; exp_m / exp_id are the hand-derived master
   // port and stripped ID the beat must arrive with.
   task automatic send(input int s, input logic [IDS_W-1:0] rid,
                       input logic exp_m, input logic [ID_W-1:0] exp_id,
                       input logic [DATA_W-1:0] data, input logic [1:0] resp,
                       input logic last, input logic exp_en);
      slv_q[s].push_back({rid, data, resp, last});
      if (exp_en) exp_q.push_back({exp_m, exp_id, data, resp, last});
   endtask

   task automatic wait_valid(input int s, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_valid[s] && n < budget);
      if (!s_valid[s]) check("wait_valid_timeout", 64'(s_valid[s]), 64'd1);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || slv_q[0].size() != 0 || slv_q[1].size() != 0 ||
              slv_q[2].size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_exp_q", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------------------------------------------------------------
   // Slave model: advance to the next beat after each accepted handshake
   // ---------------------------------------------------------------------
   initial begin
      logic [2:0] hs;
      for (int s = 0; s < 3; s++) begin
         s_rid[s] = '0; s_data[s] = '0; s_resp[s] = '0;
      end
      s_last  = '0;
      s_valid = '0;
      forever begin
         @(negedge clk);
         hs = s_valid & s_ready;
         @(posedge clk);
         #1;
         for (int s = 0; s < 3; s++) begin
            if (hs[s] && slv_q[s].size() > 0) void'(slv_q[s].pop_front());
            if (slv_q[s].size() > 0) begin
               {s_rid[s], s_data[s], s_resp[s], s_last[s]} = slv_q[s][0];
               s_valid[s] = 1'b1;
            end else begin
               s_rid[s] = '0; s_data[s] = '0; s_resp[s] = '0;
               s_last[s] = 1'b0; s_valid[s] = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Scoreboard monitor
   // ---------------------------------------------------------------------
   initial begin
      logic [SB_W-1:0] got;
      logic [SB_W-1:0] exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int m = 0; m < 2; m++) begin
               if (m_valid[m] && m_ready[m]) begin
                  got = {1'(m), m_id[m], m_data[m], m_resp[m], m_last[m]};
                  if (exp_q.size() == 0) begin
                     check("unexpected_beat", 64'(got), 64'd0);
                  end else begin
                     exp = exp_q.pop_front();
                     check("beat", 64'(got), 64'(exp));
                     check("other_master_idle",
                           64'({m_valid[1-m], m_id[1-m], m_data[1-m], m_resp[1-m], m_last[1-m]}),
                           64'd0);
                  end
               end
            end
         end
      end
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

   // ---------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------
   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      check("rst_ptr", 64'(dbg_ptr), 64'd0);
      check("rst_owner", 64'(dbg_owner), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_m_data", 64'({m_data[0], m_data[1]}), 64'd0);
`ifdef READ_WATCHDOG_EN
      check("rst_timeout", 64'(rd_timeout), 64'd0);
`endif
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check("idle_no_valid_m", 64'({m_valid, m_last, m_id[0], m_id[1]}), 64'd0);

      // 1) single beat S1 -> M1
      m_ready = 2'b11;
      send(1, 8'h13, 1'b1, 4'h3, 32'hDEADBEEF, RRESP_OKAY, 1'b1, 1'b1);
      wait_valid(1, 10);
      check("t1_valid_m1", 64'(m_valid[1]), 64'd1);
      check("t1_rid_m1", 64'(m_id[1]), 64'h3);
      check("t1_data_m1", 64'(m_data[1]), 64'hDEADBEEF);
      check("t1_ready_s", 64'(s_ready), 64'b010);
      check("t1_m0_idle", 64'({m_valid[0], m_data[0]}), 64'd0);
      @(negedge clk);
      check("t1_ptr", 64'(dbg_ptr), 64'd2);
      check("t1_state", 64'(dbg_state), 64'(IDLE));

      // 2) 4-beat burst S0 -> M0, beat 2 stalled 3 cycles
      for (int i = 0; i < 4; i++)
         send(0, 8'h05, 1'b0, 4'h5, 32'h1000_0000 + 32'(i),
              (i == 2) ? RRESP_SLVERR : RRESP_OKAY, (i == 3), 1'b1);
      wait_valid(0, 10);
      check("t2_first_state", 64'(dbg_state), 64'(IDLE));
      @(posedge clk); #1 m_ready[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t2_hold_valid", 64'(m_valid[0]), 64'd1);
         check("t2_hold_data", 64'(m_data[0]), 64'h1000_0001);
         check("t2_hold_ready", 64'(s_ready), 64'd0);
         check("t2_hold_state", 64'(dbg_state), 64'(LOCK));
      end
      @(posedge clk); #1 m_ready[0] = 1'b1;
      wait_drain(20);
      check("t2_end_state", 64'(dbg_state), 64'(IDLE));
      check("t2_end_ptr", 64'(dbg_ptr), 64'd1);

      // 3) contention from reset: S0, S1, S2 served in consecutive cycles
      @(posedge clk); #2 rst = 1'b1;
      send(0, 8'h01, 1'b0, 4'h1, 32'hA000_0000, RRESP_OKAY, 1'b1, 1'b1);
      send(1, 8'h12, 1'b1, 4'h2, 32'hA111_1111, RRESP_EXOKAY, 1'b1, 1'b1);
      send(2, 8'h07, 1'b0, 4'h7, 32'hA222_2222, RRESP_DECERR, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      check("t3_rst_m_valid", 64'(m_valid), 64'd0);
      check("t3_rst_s_ready", 64'(s_ready), 64'd0);
      check("t3_rst_ptr", 64'(dbg_ptr), 64'd0);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check("t3_serve_s0", 64'(s_ready), 64'b001);
      @(negedge clk);
      check("t3_serve_s1", 64'(s_ready), 64'b010);
      @(negedge clk);
      check("t3_serve_s2", 64'(s_ready), 64'b100);
      wait_drain(20);
      check("t3_ptr", 64'(dbg_ptr), 64'd0);

      // 4) lock fairness: S0 waits behind S2's burst
      for (int i = 0; i < 3; i++)
         send(2, 8'h1A, 1'b1, 4'hA, 32'h2000_0000 + 32'(i), RRESP_OKAY, (i == 2), 1'b1);
      wait_valid(2, 10);
      @(posedge clk); #1;
      send(0, 8'h02, 1'b0, 4'h2, 32'h3000_0000, RRESP_OKAY, 1'b1, 1'b1);
      @(negedge clk);
      check("t4_b2_s_ready", 64'(s_ready), 64'b100);
      check("t4_b2_state", 64'(dbg_state), 64'(LOCK));
      check("t4_b2_owner", 64'(dbg_owner), 64'd2);
      @(negedge clk);
      check("t4_b3_s_ready", 64'(s_ready), 64'b100);
      check("t4_b3_m0_valid", 64'(m_valid[0]), 64'd0);
      @(negedge clk);
      check("t4_s0_ready", 64'(s_ready), 64'b001);
      check("t4_s0_data", 64'({m_valid[0], m_data[0]}), {31'd0, 1'b1, 32'h3000_0000});
      check("t4_s0_state", 64'(dbg_state), 64'(IDLE));
      wait_drain(20);
      check("t4_ptr", 64'(dbg_ptr), 64'd1);

      // 5) reset during LOCK on beat 2 of 4
      for (int i = 0; i < 4; i++)
         send(1, 8'h14, 1'b1, 4'h4, 32'h4000_0000 + 32'(i), RRESP_OKAY, (i == 3), (i == 0));
      wait_valid(1, 10);
      @(posedge clk); #1 m_ready[1] = 1'b0;
      @(negedge clk);
      check("t5_lock_state", 64'(dbg_state), 64'(LOCK));
      check("t5_lock_data", 64'({m_valid[1], m_data[1]}), {31'd0, 1'b1, 32'h4000_0001});
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("t5_rst_m_valid", 64'(m_valid), 64'd0);
      check("t5_rst_s_ready", 64'(s_ready), 64'd0);
      check("t5_rst_state", 64'(dbg_state), 64'(IDLE));
      check("t5_rst_data", 64'({m_data[1], m_id[1]}), 64'd0);
      for (int s = 0; s < 3; s++) slv_q[s].delete();
      check("t5_exp_left", 64'(exp_q.size()), 64'd0);
      m_ready[1] = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check("t5_after_state", 64'(dbg_state), 64'(IDLE));
      check("t5_after_ptr", 64'(dbg_ptr), 64'd0);

`ifdef READ_WATCHDOG_EN
      // 6) watchdog: S1 locked toward M0 with RREADY_M0 held low
      m_ready[0] = 1'b0;
      send(1, 8'h06, 1'b0, 4'h6, 32'h5000_0000, RRESP_OKAY, 1'b0, 1'b1);
      send(1, 8'h06, 1'b0, 4'h6, 32'h5000_0001, RRESP_OKAY, 1'b1, 1'b1);
      wait_valid(1, 10);
      check("t6_pre_timeout", 64'(rd_timeout), 64'd0);
      repeat (8) @(negedge clk);
      check("t6_at_7_stalls", 64'(rd_timeout), 64'd0);
      @(negedge clk);
      check("t6_after_8_stalls", 64'(rd_timeout), 64'd1);
      @(posedge clk); #1 m_ready[0] = 1'b1;
      wait_drain(20);
      check("t6_sticky", 64'(rd_timeout), 64'd1);
      check("t6_state", 64'(dbg_state), 64'(IDLE));
`endif

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
